// File: rtl/sr16_deserializer_if.sv
// rtl/sr16_deserializer_if.sv - serial-in / word-out bundle for sr16_deserializer
//
// Purpose: groups the serial input pair and the parallel word output.
// Signals:
//   datain  [1:0]        serial bits for this cycle
//   ctrl    [1:0]        bit-count qualifier for datain
//   valid                one-cycle strobe, dataout holds a new word
//   dataout [WIDTH-1:0]  last completed word
// Modports: master drives datain/ctrl, slave (the deserializer) drives
// valid/dataout.
interface sr16_deserializer_if #(
   parameter int WIDTH = 16
);
   logic [1:0]       datain;
   logic [1:0]       ctrl;
   logic             valid;
   logic [WIDTH-1:0] dataout;

   modport master (
      output datain,
      output ctrl,
      input  valid,
      input  dataout
   );

   modport slave (
      input  datain,
      input  ctrl,
      output valid,
      output dataout
   );
endinterface

// File: rtl/sr16_deserializer.sv
// rtl/sr16_deserializer.sv - 0/1/2-bit-per-cycle serial to 16-bit parallel shift register
//
// Purpose: assembles serial bits MSB-first into WIDTH-bit words and strobes
// valid for one cycle when a word completes.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   sr16_deserializer_if.slave (datain, ctrl in; valid, dataout out)
// ctrl: 00 none, 01 datain[0], 10 datain[1], 11 datain[1] then datain[0].
module sr16_deserializer #(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   sr16_deserializer_if.slave    bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
   localparam logic [CW-1:0] PENULT   = CW'(WIDTH - 2);

   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] dout_q, dout_d;

   logic [WIDTH-1:0] shift_one;
   logic [WIDTH-1:0] shift_two;
   logic             single_bit;

   always_comb begin
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      dout_d  = dout_q;

      // For ctrl=11 the earlier bit is datain[1]; for single transfers the
      // selected bit is whichever lane ctrl names.
      single_bit = bus.ctrl[1] ? bus.datain[1] : bus.datain[0];
      shift_one  = {sr_q[WIDTH-2:0], single_bit};
      shift_two  = {sr_q[WIDTH-3:0], bus.datain[1], bus.datain[0]};

      unique case (bus.ctrl)
         2'b01, 2'b10: begin
            sr_d = shift_one;
            if (cnt_q == LAST) begin
               dout_d  = shift_one;
               valid_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         2'b11: begin
            sr_d = shift_two;
            if (cnt_q == LAST) begin
               // datain[1] closes this word; datain[0] already sits in the
               // LSB of sr_d as the first bit of the next word.
               dout_d  = shift_one;
               valid_d = 1'b1;
               cnt_d   = CW'(1);
            end else if (cnt_q == PENULT) begin
               dout_d  = shift_two;
               valid_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(2);
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         dout_q  <= '0;
      end else begin
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         dout_q  <= dout_d;
      end
   end

   assign bus.valid   = valid_q;
   assign bus.dataout = dout_q;
endmodule

// File: tb/tb_sr16_deserializer.sv
// tb/tb_sr16_deserializer.sv - self-checking bench for sr16_deserializer
module tb_sr16_deserializer;
   logic clk;
   logic rst;

   sr16_deserializer_if #(.WIDTH(16)) ifc ();

   sr16_deserializer #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ctrl;
      logic [1:0]  din;
      logic        exp_valid;
      logic [15:0] exp_dout;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          mcnt     = 0;
   int          pulses   = 0;
   logic [15:0] last_exp = 16'h0000;
   logic [15:0] exp_q[$];
   vec_t        tbl[$];

   always @(negedge clk) if (ifc.valid === 1'b1) pulses++;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the scoreboard pops the next expected word
   // whenever the bit count of the bench's word tracker reaches 16.
   task automatic step(input logic [1:0] c, input logic [1:0] d);
      logic expv;
      @(negedge clk);
      ifc.ctrl   = c;
      ifc.datain = d;
      @(posedge clk);
      #1;
      mcnt += int'(c[1]) + int'(c[0]);
      expv = 1'b0;
      if (mcnt >= 16) begin
         mcnt -= 16;
         expv = 1'b1;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got completion expected none at %0t", $time);
         end else begin
            last_exp = exp_q.pop_front();
         end
      end
      check("valid", {15'b0, ifc.valid}, {15'b0, expv});
      check("dataout", ifc.dataout, last_exp);
   endtask

   initial begin
      logic [15:0] w;
      logic        b;

      // Mixed-stall table for 0x1234: a stall before every third bit, even
      // bits on lane 1 and odd bits on lane 0, the unused lane inverted.
      w = 16'h1234;
      for (int k = 0; k < 16; k++) begin
         b = w[15-k];
         if (k % 3 == 0) tbl.push_back('{2'b00, 2'b11, 1'b0, 16'h82FC});
         if (k % 2 == 0) tbl.push_back('{2'b10, {b, ~b}, 1'b0, 16'h82FC});
         else            tbl.push_back('{2'b01, {~b, b}, 1'b0, 16'h82FC});
      end
      tbl[tbl.size()-1].exp_valid = 1'b1;
      tbl[tbl.size()-1].exp_dout  = 16'h1234;

      // Test 1: reset held with arbitrary inputs, then idle cycles.
      rst        = 1'b0;
      ifc.ctrl   = 2'b11;
      ifc.datain = 2'b11;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ifc.ctrl   = 2'($urandom_range(3));
         ifc.datain = 2'($urandom_range(3));
         @(posedge clk);
         #1;
         check("rst_valid", {15'b0, ifc.valid}, 16'h0);
         check("rst_dataout", ifc.dataout, 16'h0000);
      end
      @(negedge clk);
      ifc.ctrl = 2'b00;
      rst      = 1'b1;
      for (int i = 0; i < 5; i++) step(2'b00, 2'($urandom_range(3)));

      // Test 2: single-bit stream on lane 0, then hold.
      w = 16'h817E;
      exp_q.push_back(w);
      for (int i = 15; i >= 0; i--) step(2'b01, {~w[i], w[i]});
      for (int i = 0; i < 3; i++) step(2'b00, 2'b11);

      // Test 3: double-bit stream, lane 1 first in time.
      w = 16'hA5C3;
      exp_q.push_back(w);
      for (int i = 7; i >= 0; i--) step(2'b11, {w[2*i+1], w[2*i]});

      // Test 4: straddle across the word boundary.
      w = 16'h817E;
      exp_q.push_back(w);
      exp_q.push_back(16'h82FC);
      for (int i = 15; i >= 1; i--) step(2'b01, {1'b0, w[i]});
      step(2'b11, {w[0], 1'b1});
      w = 16'h82FC;
      for (int i = 14; i >= 0; i--) step(2'b01, {1'b0, w[i]});

      // Test 5: table-driven mixed transfers with stalls.
      exp_q.push_back(16'h1234);
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].ctrl, tbl[i].din);
         check("t5_valid", {15'b0, ifc.valid}, {15'b0, tbl[i].exp_valid});
         check("t5_dataout", ifc.dataout, tbl[i].exp_dout);
      end

      // Test 6: 9 bits, async reset pulse between edges, then 0xFFFF.
      w = 16'hA5C3;
      for (int i = 15; i >= 7; i--) step(2'b01, {1'b0, w[i]});
      @(negedge clk);
      ifc.ctrl = 2'b00;
      #1 rst = 1'b0;
      #1;
      check("async_rst_valid", {15'b0, ifc.valid}, 16'h0);
      check("async_rst_dataout", ifc.dataout, 16'h0000);
      #1 rst = 1'b1;
      mcnt     = 0;
      last_exp = 16'h0000;
      exp_q.push_back(16'hFFFF);
      for (int i = 0; i < 16; i++) step(2'b01, 2'b01);
      step(2'b00, 2'b00);

      check("pulse_count", 16'(pulses), 16'd6);
      check("scoreboard_left", 16'(exp_q.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
